// File: rtl/com_op_code_pkg.sv
// Purpose: shared op-code index map, FSM state type and op classification helpers
//          for the firmware op-code dispatcher.
// Latency: n/a (types and constants only). Backpressure: n/a.
package com_op_code_pkg;

   // Fixed op-code index map; bit i of the one-hot strobe corresponds to code i.
   typedef enum logic [3:0] {
      OP_W_RESET          = 4'd0,
      OP_W_CFG_STATIC_0   = 4'd1,
      OP_R_CFG_STATIC_0   = 4'd2,
      OP_W_CFG_STATIC_1   = 4'd3,
      OP_R_CFG_STATIC_1   = 4'd4,
      OP_W_CFG_ARRAY_0    = 4'd5,
      OP_R_CFG_ARRAY_0    = 4'd6,
      OP_W_CFG_ARRAY_1    = 4'd7,
      OP_R_CFG_ARRAY_1    = 4'd8,
      OP_R_DATA_ARRAY_0   = 4'd9,
      OP_R_DATA_ARRAY_1   = 4'd10,
      OP_W_STATUS_CLEAR   = 4'd11,
      OP_W_EXECUTE        = 4'd12
   } op_code_e;

   localparam int NUM_OPS_DEFAULT = 13;

   // Ops that finish in their strobe cycle and never wait for op_done.
   localparam logic [NUM_OPS_DEFAULT-1:0] SELF_COMPLETING =
      (NUM_OPS_DEFAULT'(1) << OP_W_RESET) | (NUM_OPS_DEFAULT'(1) << OP_W_STATUS_CLEAR);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_e;

   // Shift-based lookup so indices beyond the map simply return 0.
   function automatic logic is_self_completing(input int unsigned idx);
      logic [NUM_OPS_DEFAULT-1:0] bit_sel;
      bit_sel = NUM_OPS_DEFAULT'(1) << idx;
      return |(bit_sel & SELF_COMPLETING);
   endfunction

   function automatic logic is_status_clear(input int unsigned idx);
      return idx == 32'(OP_W_STATUS_CLEAR);
   endfunction

endpackage

// File: rtl/com_op_code_onehot.sv
// Purpose: binary-to-one-hot decoder with an out-of-range flag.
// Latency: combinational. Backpressure: none.
// Ports: idx (binary in), onehot (OUT_W one-hot out, all-zero when out of range),
//        out_of_range (idx >= OUT_W).
module com_op_code_onehot #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 13
) (
   input  logic [IN_W-1:0]  idx,
   output logic [OUT_W-1:0] onehot,
   output logic             out_of_range
);

   assign out_of_range = (32'(idx) >= 32'(OUT_W));

   always_comb begin
      onehot = '0;
      for (int i = 0; i < OUT_W; i++) begin
         onehot[i] = (32'(idx) == 32'(i));
      end
   end

endmodule

// File: rtl/com_op_code_dispatch.sv
// Purpose: qualifies firmware op-code writes by device ID, decodes them to a one-hot
//          strobe and sequences each operation with a busy/done handshake.
// Latency: strobe accepted at edge N -> op_code high in cycle N+1 (registered outputs).
// Backpressure: busy high while an op is in flight; matched writes while busy are
//          dropped and flagged in err_overrun.
// Ports: clk, reset (sync, active-high); fw_op_code/fw_dev_id/fw_op_code_valid (command
//        write); op_done (engine completion); op_code (one-hot strobe); busy;
//        err_illegal/err_overrun (sticky flags); cmd_count (accepted commands, wraps).
module com_op_code_dispatch
   import com_op_code_pkg::*;
#(
   parameter int OP_CODE_W    = 4,
   parameter int NUM_OPS      = 13,
   parameter int DEV_ID_W     = 2,
   parameter int DEV_ID       = 0,
   parameter int BROADCAST_EN = 1,
   parameter int LEVEL_MODE   = 0,
   parameter int CNT_W        = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [OP_CODE_W-1:0] fw_op_code,
   input  logic [DEV_ID_W-1:0]  fw_dev_id,
   input  logic                 fw_op_code_valid,
   input  logic                 op_done,
   output logic [NUM_OPS-1:0]   op_code,
   output logic                 busy,
   output logic                 err_illegal,
   output logic                 err_overrun,
   output logic [CNT_W-1:0]     cmd_count
);

   state_e             state;
   logic               self_comp;   // latched: active op completes without op_done
   logic               clr_op;      // latched: active op is w_status_clear
   logic               match;
   logic [NUM_OPS-1:0] dec_onehot;
   logic               dec_oob;

   assign match = fw_op_code_valid &
                  ((fw_dev_id == DEV_ID_W'(DEV_ID)) |
                   ((BROADCAST_EN != 0) && (fw_dev_id == '1)));

   com_op_code_onehot #(
      .IN_W  (OP_CODE_W),
      .OUT_W (NUM_OPS)
   ) u_onehot (
      .idx          (fw_op_code),
      .onehot       (dec_onehot),
      .out_of_range (dec_oob)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         op_code     <= '0;
         busy        <= 1'b0;
         err_illegal <= 1'b0;
         err_overrun <= 1'b0;
         cmd_count   <= '0;
         self_comp   <= 1'b0;
         clr_op      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (match) begin
                  if (dec_oob) begin
                     err_illegal <= 1'b1;
                  end else begin
                     state     <= ST_ISSUE;
                     op_code   <= dec_onehot;
                     busy      <= 1'b1;
                     cmd_count <= cmd_count + CNT_W'(1);
                     self_comp <= is_self_completing(32'(fw_op_code));
                     clr_op    <= is_status_clear(32'(fw_op_code));
                  end
               end
            end

            ST_ISSUE: begin
               // Status clear wipes both flags, but an overrun landing in the
               // same cycle must survive the clear.
               if (clr_op) begin
                  err_illegal <= 1'b0;
                  err_overrun <= match;
               end else if (match) begin
                  err_overrun <= 1'b1;
               end

               if (self_comp) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  op_code <= '0;
               end else begin
                  state <= ST_WAIT_DONE;
                  if (LEVEL_MODE == 0) begin
                     op_code <= '0;
                  end
               end
            end

            ST_WAIT_DONE: begin
               // A command coinciding with op_done is still an overrun.
               if (match) begin
                  err_overrun <= 1'b1;
               end
               if (op_done) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  op_code <= '0;
               end
            end

            default: begin
               state   <= ST_IDLE;
               busy    <= 1'b0;
               op_code <= '0;
            end
         endcase
      end
   end

endmodule
